// File: rtl/conv_encoder_param_if.sv
// Valid/ready stream bundle for conv_encoder_param: data words in, coded words out.
// The slave modport is the encoder side; the master modport is the producer/consumer side.
interface conv_encoder_param_if #(
  parameter int DATA_W = 8,
  parameter int N      = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  in_last;
  logic                  tail_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*DATA_W-1:0]   out_data;
  logic                  out_last;

  modport slave (
    input  in_valid, in_data, in_last, tail_en, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, tail_en, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_encoder_param.sv
// Rate-1/N feed-forward convolutional encoder: one word in, encoded MSB first one bit per
// cycle, one N*DATA_W coded word out, optional zero-tail termination at end of frame.
module conv_encoder_param #(
  parameter int               DATA_W = 8,
  parameter int               K      = 8,
  parameter int               N      = 2,
  parameter logic [N*K-1:0]   G      = {8'b11110001, 8'b10110111}
) (
  input  logic                 clk,
  input  logic                 reset_n,
  conv_encoder_param_if.slave  bus
);

  localparam int OW    = N * DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  generate
    if (K < 2 || N < 1 || (K - 1) > DATA_W) begin : g_bad_params
      $error("conv_encoder_param: need K >= 2, N >= 1 and K-1 <= DATA_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_data;
  logic [K-2:0]      r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic [OW-1:0]     r_out;
  logic              r_last;
  logic              r_tail_en;
  logic              r_is_tail;

  logic [K-1:0]      w_win;
  logic [N-1:0]      w_sym;
  logic              w_out_last;
  logic              w_start_tail;

  // Window: current bit on top, most recent past bit just below it.
  assign w_win        = {r_data[DATA_W-1], r_sr};
  assign w_out_last   = r_is_tail | (r_last & ~r_tail_en);
  assign w_start_tail = r_last & r_tail_en & ~r_is_tail;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_sym[i] = ^(G[i*K +: K] & w_win);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // NOTE: default assignment first, so no path through the case leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)        w_next = ENC;
      ENC:     if (r_cnt == LAST_CNT)   w_next = OUT;
      OUT:     if (bus.out_ready)       w_next = w_start_tail ? ENC : IDLE;
      default:                          w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE:    bus.in_ready  = 1'b1;
      OUT:     bus.out_valid = 1'b1;
      default: ;
    endcase
    bus.out_data = r_out;
    bus.out_last = (r_state == OUT) & w_out_last;
  end

  // Symbols shift in from the bottom, so after DATA_W steps the first bit's symbol sits on top.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_out     <= '0;
      r_last    <= 1'b0;
      r_tail_en <= 1'b0;
      r_is_tail <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_data    <= bus.in_data;
            r_last    <= bus.in_last;
            r_tail_en <= bus.tail_en;
            r_is_tail <= 1'b0;
            r_cnt     <= '0;
          end
        end
        ENC: begin
          r_data <= r_data << 1;
          r_sr   <= w_win[K-1:1];
          r_out  <= (r_out << N) | OW'(w_sym);
          r_cnt  <= r_cnt + 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            if (w_start_tail) begin
              r_data    <= '0;
              r_is_tail <= 1'b1;
              r_cnt     <= '0;
            end else if (w_out_last) begin
              // Frame ends here: truncated frames drop their history.
              r_sr <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed and table-driven checks for conv_encoder_param (default K=8/N=2/DATA_W=8)
// plus a K=3/N=3/DATA_W=4 instance compared against a bit-level model.
module tb_conv_encoder_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  conv_encoder_param_if #(.DATA_W(8), .N(2)) b1 ();
  conv_encoder_param_if #(.DATA_W(4), .N(3)) b2 ();

  conv_encoder_param u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b1)
  );

  localparam logic [8:0] G2 = {3'b101, 3'b111, 3'b011};

  conv_encoder_param #(.DATA_W(4), .K(3), .N(3), .G(G2)) u_dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b2)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0]  din;
    logic        last;
    logic        tail;
    logic [15:0] exp_data;
    logic        exp_last;
    logic [15:0] exp_tail;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send1(input logic [7:0] d, input logic l, input logic t);
    int n = 0;
    @(negedge clk);
    b1.in_data = d; b1.in_last = l; b1.tail_en = t; b1.in_valid = 1'b1;
    while (!b1.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!b1.in_ready) check("send1 in_ready timeout", 64'(b1.in_ready), 64'd1);
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
  endtask

  task automatic get1(input string name, input logic [15:0] ed, input logic el);
    int n = 0;
    while (!b1.out_valid && n < 100) begin @(negedge clk); n++; end
    check({name, " out_valid"}, 64'(b1.out_valid), 64'd1);
    check({name, " out_data"},  64'(b1.out_data),  64'(ed));
    check({name, " out_last"},  64'(b1.out_last),  64'(el));
    @(negedge clk); b1.out_ready = 1'b1;
    @(posedge clk); #1;
    b1.out_ready = 1'b0;
  endtask

  task automatic send2(input logic [3:0] d, input logic l, input logic t);
    int n = 0;
    @(negedge clk);
    b2.in_data = d; b2.in_last = l; b2.tail_en = t; b2.in_valid = 1'b1;
    while (!b2.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!b2.in_ready) check("send2 in_ready timeout", 64'(b2.in_ready), 64'd1);
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
  endtask

  task automatic get2(input string name, input logic [11:0] ed, input logic el);
    int n = 0;
    while (!b2.out_valid && n < 100) begin @(negedge clk); n++; end
    check({name, " out_valid"}, 64'(b2.out_valid), 64'd1);
    check({name, " out_data"},  64'(b2.out_data),  64'(ed));
    check({name, " out_last"},  64'(b2.out_last),  64'(el));
    @(negedge clk); b2.out_ready = 1'b1;
    @(posedge clk); #1;
    b2.out_ready = 1'b0;
  endtask

  // Bit-level reference for the K=3/N=3/DATA_W=4 instance.
  function automatic logic [11:0] enc2(input logic [3:0] d, input logic [1:0] sr_in,
                                       output logic [1:0] sr_out);
    logic [11:0] o;
    logic [1:0]  sr;
    logic [2:0]  w;
    o  = '0;
    sr = sr_in;
    for (int t = 0; t < 4; t++) begin
      w = {d[3-t], sr};
      for (int i = 0; i < 3; i++) o[(3-t)*3 + i] = ^(G2[i*3 +: 3] & w);
      sr = w[2:1];
    end
    sr_out = sr;
    return o;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    int n;
    logic [3:0]  d2;
    logic        l2, t2;
    logic [1:0]  sr2, nsr2, tmp_sr;
    logic [11:0] e2, e2_tail;

    b1.in_valid = 0; b1.in_data = '0; b1.in_last = 0; b1.tail_en = 0; b1.out_ready = 0;
    b2.in_valid = 0; b2.in_data = '0; b2.in_last = 0; b2.tail_en = 0; b2.out_ready = 0;

    //           din    last  tail  exp_data  exp_last exp_tail
    vecs[0]  = '{8'h80, 1'b1, 1'b0, 16'hEF17, 1'b0 | 1'b1, 16'h0000};
    vecs[1]  = '{8'h01, 1'b1, 1'b1, 16'h0003, 1'b0, 16'hBC5C};
    vecs[2]  = '{8'h01, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0000};
    vecs[3]  = '{8'h00, 1'b1, 1'b0, 16'hBC5C, 1'b1, 16'h0000};
    vecs[4]  = '{8'h80, 1'b1, 1'b0, 16'hEF17, 1'b1, 16'h0000};
    vecs[5]  = '{8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vecs[6]  = '{8'h01, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0000};
    vecs[7]  = '{8'h80, 1'b1, 1'b0, 16'h534B, 1'b1, 16'h0000};
    vecs[8]  = '{8'h80, 1'b1, 1'b1, 16'hEF17, 1'b0, 16'h0000};
    vecs[9]  = '{8'h80, 1'b0, 1'b0, 16'hEF17, 1'b0, 16'h0000};
    vecs[10] = '{8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready",  64'(b1.in_ready),  64'd1);
    check("reset out_valid", 64'(b1.out_valid), 64'd0);
    check("reset out_data",  64'(b1.out_data),  64'd0);
    check("reset out_last",  64'(b1.out_last),  64'd0);
    check("reset2 in_ready", 64'(b2.in_ready),  64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Zero word from reset, then latency of an impulse word
    send1(8'h00, 1'b1, 1'b0);
    get1("zero", 16'h0000, 1'b1);
    send1(8'h80, 1'b1, 1'b0);
    lat = 0;
    while (!b1.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("latency cycles", 64'(lat), 64'd8);
    get1("impulse", 16'hEF17, 1'b1);

    // Table-driven frames
    for (int i = 0; i < 11; i++) begin
      send1(vecs[i].din, vecs[i].last, vecs[i].tail);
      get1($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_last);
      if (vecs[i].last && vecs[i].tail) begin
        get1($sformatf("vec%0d tail", i), vecs[i].exp_tail, 1'b1);
        check($sformatf("vec%0d in_ready after tail", i), 64'(b1.in_ready), 64'd1);
      end
    end

    // Backpressure: output held, input ignored while stalled
    send1(8'h80, 1'b1, 1'b0);
    n = 0;
    while (!b1.out_valid && n < 100) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b1.in_valid = k[0];
      b1.in_data  = 8'h55;
      check($sformatf("bp%0d out_data", k), 64'(b1.out_data),  64'hEF17);
      check($sformatf("bp%0d out_last", k), 64'(b1.out_last),  64'd1);
      check($sformatf("bp%0d in_ready", k), 64'(b1.in_ready),  64'd0);
    end
    @(negedge clk);
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    b1.out_ready = 1'b0;
    check("bp accepted out_valid", 64'(b1.out_valid), 64'd0);
    check("bp accepted in_ready",  64'(b1.in_ready),  64'd1);
    seen = 0;
    repeat (12) begin @(negedge clk); if (b1.out_valid) seen++; end
    check("bp no extra word", 64'(seen), 64'd0);

    // Reset in the middle of encoding, three bits in
    send1(8'h80, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset out_valid", 64'(b1.out_valid), 64'd0);
    check("midreset in_ready",  64'(b1.in_ready),  64'd1);
    check("midreset out_data",  64'(b1.out_data),  64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send1(8'h80, 1'b1, 1'b0);
    get1("after midreset", 16'hEF17, 1'b1);

    // K=3, N=3, DATA_W=4 instance: hand-computed impulse, then random frames against the model
    send2(4'h8, 1'b1, 1'b0);
    get2("k3 impulse", 12'b110_011_111_000, 1'b1);
    sr2 = '0;
    for (int w = 0; w < 24; w++) begin
      d2 = 4'($urandom_range(0, 15));
      l2 = ($urandom_range(0, 3) == 0);
      t2 = 1'($urandom_range(0, 1));
      e2 = enc2(d2, sr2, nsr2);
      send2(d2, l2, t2);
      if (l2 && t2) begin
        get2($sformatf("rand%0d", w), e2, 1'b0);
        e2_tail = enc2(4'h0, nsr2, tmp_sr);
        get2($sformatf("rand%0d tail", w), e2_tail, 1'b1);
        sr2 = '0;
      end else begin
        get2($sformatf("rand%0d", w), e2, l2);
        sr2 = l2 ? 2'b00 : nsr2;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
